// File: rtl/sdram_stream_scheduler.sv
// Ring-buffer burst sequencer between the stream FIFOs and the SDRAM controller.
// Optional burst/late-refresh statistics are built when SDRAM_SCHED_STATS_EN is defined.
module sdram_stream_scheduler #(
   parameter int ADDR_W     = 24,
   parameter int BURST      = 256,
   parameter int USEDW_W    = 10,
   parameter int REF_PERIOD = 374
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic [USEDW_W-1:0]  wr_usedw,
   input  logic [USEDW_W-1:0]  rd_free,
   output logic                cmd_req,
   output logic [1:0]          cmd_op,
   output logic [ADDR_W-1:0]   cmd_addr,
   input  logic                cmd_ack,
   input  logic                cmd_done,
   output logic [ADDR_W:0]     fill,
   output logic                ring_full,
   output logic                ring_empty,
   output logic                busy,
   output logic [15:0]         wr_bursts,
   output logic [15:0]         rd_bursts,
   output logic                ref_late
);

   localparam logic [1:0] OP_WR  = 2'd0;
   localparam logic [1:0] OP_RD  = 2'd1;
   localparam logic [1:0] OP_REF = 2'd2;

   localparam int                REF_W      = $clog2(REF_PERIOD + 1);
   localparam logic [REF_W-1:0]  REF_LAST   = REF_W'(REF_PERIOD - 1);
   localparam logic [31:0]       BURST_LVL  = 32'(BURST);
   localparam logic [ADDR_W:0]   L_BURST    = (ADDR_W+1)'(BURST);
   localparam logic [ADDR_W:0]   L_RING     = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0]   L_FULL_TH  = L_RING - L_BURST;
   localparam logic [ADDR_W-1:0] L_PTR_STEP = ADDR_W'(BURST);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_DONE
   } state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_wr_ptr;
   logic [ADDR_W-1:0]   r_rd_ptr;
   logic [ADDR_W:0]     r_fill;
   logic                r_full;
   logic                r_empty;
   logic                r_req;
   logic                r_busy;
   logic [1:0]          r_op;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_last_wr;
   logic                r_ref_pending;
   logic [REF_W-1:0]    r_ref_cnt;

   logic [31:0]         w_wr_lvl;
   logic [31:0]         w_rd_lvl;
   logic                w_ref_wrap;
   logic                w_wr_elig;
   logic                w_rd_elig;
   logic                w_grant_ref;
   logic                w_grant_wr;
   logic                w_grant_rd;
   logic                w_ack;
   logic                w_done;
   logic                w_ref_ack;
   logic [ADDR_W:0]     w_fill_nxt;

   assign w_wr_lvl   = 32'(wr_usedw);
   assign w_rd_lvl   = 32'(rd_free);
   assign w_ref_wrap = (r_ref_cnt == REF_LAST);

   assign w_wr_elig  = enable && (w_wr_lvl >= BURST_LVL) && !r_full;
   assign w_rd_elig  = !r_empty && (w_rd_lvl >= BURST_LVL);

   // Refresh dominates; a contested write/read goes to whichever lost last time.
   assign w_grant_ref = r_ref_pending;
   assign w_grant_wr  = !r_ref_pending && w_wr_elig && (!w_rd_elig || !r_last_wr);
   assign w_grant_rd  = !r_ref_pending && w_rd_elig && !w_grant_wr;

   // A done arriving together with the ack is taken as ack-then-done.
   assign w_ack     = (r_state == S_ISSUE) && cmd_ack;
   assign w_done    = cmd_done && ((r_state == S_WAIT_DONE) || w_ack);
   assign w_ref_ack = w_ack && (r_op == OP_REF);

   always_comb begin
      w_fill_nxt = r_fill;
      if (w_done && (r_op == OP_WR)) begin
         w_fill_nxt = r_fill + L_BURST;
      end else if (w_done && (r_op == OP_RD)) begin
         w_fill_nxt = r_fill - L_BURST;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_fill        <= '0;
         r_full        <= 1'b0;
         r_empty       <= 1'b1;
         r_req         <= 1'b0;
         r_busy        <= 1'b0;
         r_op          <= OP_WR;
         r_addr        <= '0;
         r_last_wr     <= 1'b0;
         r_ref_pending <= 1'b0;
         r_ref_cnt     <= '0;
      end else begin
         r_ref_cnt <= w_ref_wrap ? '0 : r_ref_cnt + 1'b1;
         if (w_ref_wrap) begin
            r_ref_pending <= 1'b1;
         end else if (w_ref_ack) begin
            r_ref_pending <= 1'b0;
         end

         // Flags are derived from the next fill so they move with it.
         r_fill  <= w_fill_nxt;
         r_full  <= (w_fill_nxt > L_FULL_TH);
         r_empty <= (w_fill_nxt < L_BURST);
         if (w_done && (r_op == OP_WR)) begin
            r_wr_ptr <= r_wr_ptr + L_PTR_STEP;
         end
         if (w_done && (r_op == OP_RD)) begin
            r_rd_ptr <= r_rd_ptr + L_PTR_STEP;
         end

         case (r_state)
            S_IDLE: begin
               if (w_grant_ref || w_grant_wr || w_grant_rd) begin
                  r_state <= S_ISSUE;
                  r_req   <= 1'b1;
                  r_busy  <= 1'b1;
                  if (w_grant_ref) begin
                     r_op   <= OP_REF;
                     r_addr <= '0;
                  end else if (w_grant_wr) begin
                     r_op      <= OP_WR;
                     r_addr    <= r_wr_ptr;
                     r_last_wr <= 1'b1;
                  end else begin
                     r_op      <= OP_RD;
                     r_addr    <= r_rd_ptr;
                     r_last_wr <= 1'b0;
                  end
               end
            end
            S_ISSUE: begin
               if (cmd_ack) begin
                  r_req <= 1'b0;
                  if (cmd_done) begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_state <= S_WAIT_DONE;
                  end
               end
            end
            S_WAIT_DONE: begin
               if (cmd_done) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_req   <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign cmd_req    = r_req;
   assign cmd_op     = r_op;
   assign cmd_addr   = r_addr;
   assign fill       = r_fill;
   assign ring_full  = r_full;
   assign ring_empty = r_empty;
   assign busy       = r_busy;

`ifdef SDRAM_SCHED_STATS_EN
   logic [15:0] r_wr_bursts;
   logic [15:0] r_rd_bursts;
   logic        r_ref_late;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_bursts <= '0;
         r_rd_bursts <= '0;
         r_ref_late  <= 1'b0;
      end else begin
         if (w_done && (r_op == OP_WR)) begin
            r_wr_bursts <= r_wr_bursts + 16'd1;
         end
         if (w_done && (r_op == OP_RD)) begin
            r_rd_bursts <= r_rd_bursts + 16'd1;
         end
         // A wrap finding the previous refresh still unacknowledged is a miss.
         if (w_ref_wrap && r_ref_pending && !w_ref_ack) begin
            r_ref_late <= 1'b1;
         end
      end
   end

   assign wr_bursts = r_wr_bursts;
   assign rd_bursts = r_rd_bursts;
   assign ref_late  = r_ref_late;
`else
   assign wr_bursts = 16'd0;
   assign rd_bursts = 16'd0;
   assign ref_late  = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_stream_scheduler.sv
// Directed scoreboard bench for sdram_stream_scheduler using a small ring (ADDR_W=10).
// Stats expectations follow SDRAM_SCHED_STATS_EN.
module tb_sdram_stream_scheduler;

   localparam int AW    = 10;
   localparam int BURST = 256;
   localparam int UW    = 10;
   localparam int REFP  = 1000;
`ifdef SDRAM_SCHED_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic [UW-1:0] wr_usedw;
   logic [UW-1:0] rd_free;
   logic          cmd_req;
   logic [1:0]    cmd_op;
   logic [AW-1:0] cmd_addr;
   logic          cmd_ack;
   logic          cmd_done;
   logic [AW:0]   fill;
   logic          ring_full;
   logic          ring_empty;
   logic          busy;
   logic [15:0]   wr_bursts;
   logic [15:0]   rd_bursts;
   logic          ref_late;

   typedef struct packed {
      logic [1:0]    op;
      logic [AW-1:0] addr;
   } cmd_t;

   cmd_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   m_fill  = 0;

   sdram_stream_scheduler #(
      .ADDR_W(AW), .BURST(BURST), .USEDW_W(UW), .REF_PERIOD(REFP)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable),
      .wr_usedw(wr_usedw), .rd_free(rd_free),
      .cmd_req(cmd_req), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
      .cmd_ack(cmd_ack), .cmd_done(cmd_done),
      .fill(fill), .ring_full(ring_full), .ring_empty(ring_empty), .busy(busy),
      .wr_bursts(wr_bursts), .rd_bursts(rd_bursts), .ref_late(ref_late)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic expect_cmd(input logic [1:0] op, input int addr);
      cmd_t c;
      c.op   = op;
      c.addr = AW'(addr);
      exp_q.push_back(c);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b1;
      cmd_ack  = 1'b0;
      cmd_done = 1'b0;
      m_fill   = 0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Acts as the SDRAM controller for one command: wait, compare, ack, complete.
   task automatic serve(input int ack_dly, input int done_dly);
      int   t;
      cmd_t e;
      t = 0;
      while (cmd_req !== 1'b1 && t < 3000) begin
         @(negedge clk);
         t++;
      end
      check("req_seen", 32'(cmd_req), 32'd1);
      if (cmd_req !== 1'b1) return;
      check("sb_has_entry", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() == 0) return;
      e = exp_q.pop_front();
      check("cmd_op", 32'(cmd_op), 32'(e.op));
      check("cmd_addr", 32'(cmd_addr), 32'(e.addr));
      check("busy_issue", 32'(busy), 32'd1);
      repeat (ack_dly) @(negedge clk);
      check("req_hold", 32'(cmd_req), 32'd1);
      cmd_ack = 1'b1;
      if (done_dly == 0) cmd_done = 1'b1;
      @(negedge clk);
      cmd_ack  = 1'b0;
      cmd_done = 1'b0;
      check("req_drop", 32'(cmd_req), 32'd0);
      if (done_dly > 0) begin
         repeat (done_dly - 1) @(negedge clk);
         cmd_done = 1'b1;
         @(negedge clk);
         cmd_done = 1'b0;
      end
      if (e.op == 2'd0) m_fill += BURST;
      if (e.op == 2'd1) m_fill -= BURST;
      check("fill", 32'(fill), 32'(m_fill));
      check("ring_empty", 32'(ring_empty), 32'(m_fill < BURST));
      check("ring_full", 32'(ring_full), 32'(m_fill > (1 << AW) - BURST));
      check("busy_idle", 32'(busy), 32'd0);
   endtask

   initial begin
      rst      = 1'b1;
      enable   = 1'b0;
      wr_usedw = '0;
      rd_free  = '0;
      cmd_ack  = 1'b0;
      cmd_done = 1'b0;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_req", 32'(cmd_req), 32'd0);
      check("rst_op", 32'(cmd_op), 32'd0);
      check("rst_addr", 32'(cmd_addr), 32'd0);
      check("rst_fill", 32'(fill), 32'd0);
      check("rst_full", 32'(ring_full), 32'd0);
      check("rst_empty", 32'(ring_empty), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_wrb", 32'(wr_bursts), 32'd0);
      check("rst_rdb", 32'(rd_bursts), 32'd0);
      check("rst_late", 32'(ref_late), 32'd0);

      // Write burst: ack after 2, done after 300, then next write at 256
      enable   = 1'b1;
      wr_usedw = UW'(256);
      rd_free  = '0;
      rst      = 1'b0;
      @(negedge clk);
      check("issue_latency", 32'(cmd_req), 32'd1);
      expect_cmd(2'd0, 0);
      serve(2, 300);
      @(negedge clk);
      check("min_spacing", 32'(cmd_req), 32'd1);
      expect_cmd(2'd0, 256);
      serve(2, 5);

      // Wrap and full: four writes fill the ring, reads drain it, write returns to 0
      do_reset();
      for (int i = 0; i < 4; i++) begin
         expect_cmd(2'd0, i * 256);
         serve(1, 3);
      end
      repeat (20) @(negedge clk);
      check("no_write_when_full", 32'(cmd_req), 32'd0);
      check("full_idle_busy", 32'(busy), 32'd0);
      enable  = 1'b0;
      rd_free = UW'(512);
      for (int i = 0; i < 4; i++) begin
         expect_cmd(2'd1, i * 256);
         serve(1, 0);
      end
      enable  = 1'b1;
      rd_free = '0;
      expect_cmd(2'd0, 0);
      serve(1, 3);

      // Round-robin from fill=512 with last grant a read
      do_reset();
      for (int i = 0; i < 3; i++) begin
         expect_cmd(2'd0, i * 256);
         serve(1, 2);
      end
      enable  = 1'b0;
      rd_free = UW'(512);
      expect_cmd(2'd1, 0);
      serve(1, 2);
      enable   = 1'b1;
      wr_usedw = UW'(300);
      expect_cmd(2'd0, 768);
      expect_cmd(2'd1, 256);
      expect_cmd(2'd0, 0);
      expect_cmd(2'd1, 512);
      for (int i = 0; i < 4; i++) serve(1, 2);

      // Refresh falls due mid-burst and wins the next grant
      do_reset();
      enable   = 1'b1;
      wr_usedw = UW'(256);
      rd_free  = '0;
      expect_cmd(2'd0, 0);
      serve(2, 1100);
      expect_cmd(2'd2, 0);
      expect_cmd(2'd0, 256);
      expect_cmd(2'd0, 512);
      serve(2, 4);
      serve(2, 4);
      serve(1, 2);
      check("late_single_wrap", 32'(ref_late), 32'd0);

      // Reset asserted in WAIT_DONE
      do_reset();
      expect_cmd(2'd0, 0);
      serve(1, 3);
      @(negedge clk);
      check("pre_rst_req", 32'(cmd_req), 32'd1);
      cmd_ack = 1'b1;
      @(negedge clk);
      cmd_ack = 1'b0;
      check("pre_rst_busy", 32'(busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("midrst_req", 32'(cmd_req), 32'd0);
      check("midrst_fill", 32'(fill), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_empty", 32'(ring_empty), 32'd1);
      enable = 1'b0;
      m_fill = 0;
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      cmd_done = 1'b1;
      cmd_ack  = 1'b1;
      @(negedge clk);
      cmd_done = 1'b0;
      cmd_ack  = 1'b0;
      @(negedge clk);
      check("stray_done_fill", 32'(fill), 32'd0);
      check("stray_done_busy", 32'(busy), 32'd0);
      check("stray_done_req", 32'(cmd_req), 32'd0);

      // Stats: controller stalls for two refresh periods, then 3 writes and 1 read
      enable = 1'b1;
      do_reset();
      expect_cmd(2'd0, 0);
      repeat (2 * REFP + 50) @(negedge clk);
      check("stall_req", 32'(cmd_req), 32'd1);
      check("ref_late", 32'(ref_late), 32'(STATS));
      serve(1, 3);
      expect_cmd(2'd2, 0);
      expect_cmd(2'd0, 256);
      expect_cmd(2'd0, 512);
      serve(1, 2);
      serve(1, 2);
      serve(1, 2);
      enable  = 1'b0;
      rd_free = UW'(256);
      expect_cmd(2'd1, 0);
      serve(1, 2);
      check("wr_bursts", 32'(wr_bursts), STATS ? 32'd3 : 32'd0);
      check("rd_bursts", 32'(rd_bursts), STATS ? 32'd1 : 32'd0);
      check("ref_late_sticky", 32'(ref_late), 32'(STATS));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
